// File: rtl/countdown_timer.sv
// Six-digit BCD countdown timer (MM:SS.cc) driving six active-low seven-segment displays.
// Optional feature: define COUNTDOWN_AUTORELOAD_EN to reload the last loaded value on expiry.
module countdown_timer #(
  parameter int TICK_DIV = 500000
) (
  input  logic       CLOCK_50,
  input  logic       aclr,
  input  logic       enable,
  input  logic       load_cs,
  input  logic       load_s,
  input  logic       load_min,
  input  logic [7:0] data,
  output logic [6:0] H0,
  output logic [6:0] H1,
  output logic [6:0] H2,
  output logic [6:0] H3,
  output logic [6:0] H4,
  output logic [6:0] H5,
  output logic [7:0] led,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cs0_q, cs0_d, cs1_q, cs1_d, s0_q, s0_d, s1_q, s1_d, m0_q, m0_d, m1_q, m1_d;
  logic [3:0]    n_cs0, n_cs1, n_s0, n_s1, n_m0, n_m1;
  logic [PW-1:0] pre_q, pre_d;
  logic          running_q, running_d, done_q, done_d;
  logic          any_load, load_ok, tick, value_zero, dec_zero, reload;
  logic          b0, b1, b2, b3, b4;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [7:0]    sh_cs_q, sh_cs_d, sh_s_q, sh_s_d, sh_min_q, sh_min_d;
`endif

  function automatic logic [3:0] sat(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [3:0] dec(input logic [3:0] v, input logic [3:0] top);
    return (v == 4'd0) ? top : v - 4'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Borrow chain: each digit decrements only when every lower digit is wrapping from 0.
  always_comb begin
    b0    = (cs0_q == 4'd0);
    b1    = b0 && (cs1_q == 4'd0);
    b2    = b1 && (s0_q == 4'd0);
    b3    = b2 && (s1_q == 4'd0);
    b4    = b3 && (m0_q == 4'd0);
    n_cs0 = dec(cs0_q, 4'd9);
    n_cs1 = b0 ? dec(cs1_q, 4'd9) : cs1_q;
    n_s0  = b1 ? dec(s0_q, 4'd9) : s0_q;
    n_s1  = b2 ? dec(s1_q, 4'd5) : s1_q;
    n_m0  = b3 ? dec(m0_q, 4'd9) : m0_q;
    n_m1  = b4 ? dec(m1_q, 4'd5) : m1_q;
  end

  assign any_load   = load_cs | load_s | load_min;
  assign load_ok    = (state_q != RUN);
  assign tick       = (state_q == RUN) && (pre_q == P_LAST);
  assign value_zero = ~|{m1_q, m0_q, s1_q, s0_q, cs1_q, cs0_q};
  assign dec_zero   = ~|{n_m1, n_m0, n_s1, n_s0, n_cs1, n_cs0};

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    reload  = 1'b0;
    {m1_d, m0_d, s1_d, s0_d, cs1_d, cs0_d} = {m1_q, m0_q, s1_q, s0_q, cs1_q, cs0_q};
`ifdef COUNTDOWN_AUTORELOAD_EN
    sh_cs_d  = sh_cs_q;
    sh_s_d   = sh_s_q;
    sh_min_d = sh_min_q;
`endif
    if (load_ok && load_cs) begin
      cs1_d = sat(data[7:4], 4'd9);
      cs0_d = sat(data[3:0], 4'd9);
    end
    if (load_ok && load_s) begin
      s1_d = sat(data[7:4], 4'd5);
      s0_d = sat(data[3:0], 4'd9);
    end
    if (load_ok && load_min) begin
      m1_d = sat(data[7:4], 4'd5);
      m0_d = sat(data[3:0], 4'd9);
    end
`ifdef COUNTDOWN_AUTORELOAD_EN
    if (load_ok && load_cs)  sh_cs_d  = {cs1_d, cs0_d};
    if (load_ok && load_s)   sh_s_d   = {s1_d, s0_d};
    if (load_ok && load_min) sh_min_d = {m1_d, m0_d};
`endif
    // Expiry takes precedence over a pause request arriving on the same tick.
    case (state_q)
      IDLE: begin
        if (!any_load && enable && !value_zero) begin
          state_d = RUN;
          pre_d   = '0;
        end
      end
      RUN: begin
        if (tick) begin
          pre_d = '0;
          {m1_d, m0_d, s1_d, s0_d, cs1_d, cs0_d} = {n_m1, n_m0, n_s1, n_s0, n_cs1, n_cs0};
          if (dec_zero) begin
`ifdef COUNTDOWN_AUTORELOAD_EN
            if (|{sh_min_q, sh_s_q, sh_cs_q}) begin
              reload = 1'b1;
              {m1_d, m0_d} = sh_min_q;
              {s1_d, s0_d} = sh_s_q;
              {cs1_d, cs0_d} = sh_cs_q;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else if (!enable) begin
            state_d = PAUSE;
          end
        end else if (enable) begin
          pre_d = pre_q + PW'(1);
        end else begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (!any_load && enable) state_d = RUN;
      end
      DONE: begin
        if (any_load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE) || reload;
  end

  always_ff @(posedge CLOCK_50 or negedge aclr) begin
    if (!aclr) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cs0_q     <= 4'd0;
      cs1_q     <= 4'd0;
      s0_q      <= 4'd0;
      s1_q      <= 4'd0;
      m0_q      <= 4'd0;
      m1_q      <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      sh_cs_q   <= 8'd0;
      sh_s_q    <= 8'd0;
      sh_min_q  <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cs0_q     <= cs0_d;
      cs1_q     <= cs1_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      m0_q      <= m0_d;
      m1_q      <= m1_d;
      running_q <= running_d;
      done_q    <= done_d;
`ifdef COUNTDOWN_AUTORELOAD_EN
      sh_cs_q   <= sh_cs_d;
      sh_s_q    <= sh_s_d;
      sh_min_q  <= sh_min_d;
`endif
    end
  end

  assign H0      = seg7(cs0_q);
  assign H1      = seg7(cs1_q);
  assign H2      = seg7(s0_q);
  assign H3      = seg7(s1_q);
  assign H4      = seg7(m0_q);
  assign H5      = seg7(m1_q);
  assign led     = data;
  assign running = running_q;
  assign done    = done_q;

endmodule
